lsu_ctrl: RTL

- Load/store initiator that sits between the CPU datapath and the 4 KB word-addressed data memory.
- Accepts one load/store request at a time and issues word reads/writes on the memory port.
- Byte/halfword stores are done as read-modify-write; load data is extracted and sign/zero-extended.
- Reports misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: CPU request/response and data-memory port bundle.
// slave = load/store controller side, master = CPU/memory environment side.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic [31:0]       rdata;
   logic              addr_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       mem_dout;

   modport slave (
      input  req, wr, size, sign_ext, addr, wdata, mem_dout,
      output busy, done, rdata, addr_err,
      output mem_addr, mem_din, mem_we, mem_re
   );

   modport master (
      output req, wr, size, sign_ext, addr, wdata, mem_dout,
      input  busy, done, rdata, addr_err,
      input  mem_addr, mem_din, mem_we, mem_re
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-request load/store initiator for a word-addressed data RAM.
// Byte/half access with read-modify-write stores is enabled by LSU_SUBWORD_EN.
module lsu_ctrl #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   state_t r_state;
   logic   w_in_win;
   logic   w_bad_size;
   logic   w_err;
   logic   w_word_st;

`ifdef LSU_SUBWORD_EN
   logic        r_wr;
   logic [1:0]  r_size;
   logic        r_sext;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;

   function automatic logic [31:0] f_extract(
      input logic [31:0] w,
      input logic [1:0]  sz,
      input logic        sx,
      input logic [1:0]  ln
   );
      logic [31:0] s;
      s = w >> {ln, 3'b000};
      case (sz)
         2'b00:   f_extract = {{24{sx & s[7]}}, s[7:0]};
         2'b01:   f_extract = {{16{sx & s[15]}}, s[15:0]};
         default: f_extract = s;
      endcase
   endfunction

   function automatic logic [31:0] f_merge(
      input logic [31:0] old,
      input logic [15:0] wd,
      input logic        half,
      input logic [1:0]  ln
   );
      logic [31:0] m;
      logic [31:0] d;
      if (half) begin
         m = 32'h0000_FFFF << {ln[1], 4'b0000};
         d = {2{wd}};
      end else begin
         m = 32'h0000_00FF << {ln, 3'b000};
         d = {4{wd[7:0]}};
      end
      f_merge = (old & ~m) | (d & m);
   endfunction
`else
   logic w_unused_sext;
   assign w_unused_sext = bus.sign_ext;
`endif

   // Classify the incoming request: window, size and alignment
   always_comb begin
      w_in_win = (bus.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
      case (bus.size)
         2'b10:   w_bad_size = (bus.addr[1:0] != 2'b00);
`ifdef LSU_SUBWORD_EN
         2'b01:   w_bad_size = bus.addr[0];
         2'b00:   w_bad_size = 1'b0;
`endif
         default: w_bad_size = 1'b1;
      endcase
      w_err     = w_bad_size | ~w_in_win;
      w_word_st = bus.wr & (bus.size == 2'b10);
   end

   // Request FSM; every bus output is a registered state output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.addr_err <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.mem_re   <= 1'b0;
         bus.rdata    <= '0;
         bus.mem_addr <= '0;
         bus.mem_din  <= '0;
`ifdef LSU_SUBWORD_EN
         r_wr         <= 1'b0;
         r_size       <= 2'b00;
         r_sext       <= 1'b0;
         r_lane       <= 2'b00;
         r_wdata      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  bus.busy     <= 1'b1;
                  bus.mem_addr <= bus.addr[ADDR_W+1:2];
                  if (!bus.wr) begin
                     bus.rdata <= '0;
                  end
`ifdef LSU_SUBWORD_EN
                  r_wr    <= bus.wr;
                  r_size  <= bus.size;
                  r_sext  <= bus.sign_ext;
                  r_lane  <= bus.addr[1:0];
                  r_wdata <= bus.wdata[15:0];
`endif
                  if (w_err) begin
                     bus.addr_err <= 1'b1;
                     bus.done     <= 1'b1;
                     r_state      <= S_DONE;
                  end else if (w_word_st) begin
                     bus.addr_err <= 1'b0;
                     bus.mem_din  <= bus.wdata;
                     bus.mem_we   <= 1'b1;
                     r_state      <= S_WR;
                  end else begin
                     bus.addr_err <= 1'b0;
                     bus.mem_re   <= 1'b1;
                     r_state      <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_state <= S_CAP;
            end
            S_CAP: begin
               bus.mem_re <= 1'b0;
`ifdef LSU_SUBWORD_EN
               if (r_wr) begin
                  bus.mem_din <= f_merge(bus.mem_dout, r_wdata,
                                         r_size[0], r_lane);
                  bus.mem_we  <= 1'b1;
                  r_state     <= S_WR;
               end else begin
                  bus.rdata <= f_extract(bus.mem_dout, r_size,
                                         r_sext, r_lane);
                  bus.done  <= 1'b1;
                  r_state   <= S_DONE;
               end
`else
               bus.rdata <= bus.mem_dout;
               bus.done  <= 1'b1;
               r_state   <= S_DONE;
`endif
            end
            S_WR: begin
               bus.mem_we <= 1'b0;
               bus.done   <= 1'b1;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               bus.done   <= 1'b0;
               bus.busy   <= 1'b0;
               bus.mem_we <= 1'b0;
               bus.mem_re <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
